exc_ctrl: RTL

//  Pipeline exception/interrupt controller sitting between the MEM stage and the CP0 register file.
//  - Prioritises MEM-stage exception flags and pending interrupts into one excepttype code.
//  - Drives the CP0 exception write-back inputs (excepttype, inst address, delay-slot flag).
//  - Sequences the pipeline flush, the PC redirect and the 6-bit stall vector.

---
 rtl/exc_ctrl_pkg.sv | 53 +++++
 rtl/exc_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/exc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : exc_ctrl_pkg
//  Brief   : Shared exception codes, stall encodings and event priority encoder
//  Rev     : 1.0  initial release
// ============================================================================
package exc_ctrl_pkg;

    localparam int          c_REG_BUS    = 32;
    localparam logic [31:0] c_ZERO_WORD  = 32'h0000_0000;
    localparam logic        c_RST_ACTIVE = 1'b0;

    localparam logic [31:0] c_EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] c_EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] c_EXC_INVALID = 32'h0000_000a;
    localparam logic [31:0] c_EXC_TRAP    = 32'h0000_000d;
    localparam logic [31:0] c_EXC_OVF     = 32'h0000_000c;
    localparam logic [31:0] c_EXC_ERET    = 32'h0000_000e;

    // Stall vector bit order: {wb, mem, ex, id, if, pc}
    localparam logic [5:0] c_STALL_NONE = 6'b000000;
    localparam logic [5:0] c_STALL_ID   = 6'b000111;
    localparam logic [5:0] c_STALL_EX   = 6'b001111;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // Returns the winning excepttype code, or zero when nothing is raised.
    function automatic logic [31:0] prio_enc(
        input logic int_pend,
        input logic valid,
        input logic syscall,
        input logic invalid,
        input logic trap,
        input logic ovf,
        input logic eret
    );
        logic [31:0] code;
        code = c_ZERO_WORD;
        if (int_pend)          code = c_EXC_INT;
        else if (!valid)       code = c_ZERO_WORD;
        else if (syscall)      code = c_EXC_SYSCALL;
        else if (invalid)      code = c_EXC_INVALID;
        else if (trap)         code = c_EXC_TRAP;
        else if (ovf)          code = c_EXC_OVF;
        else if (eret)         code = c_EXC_ERET;
        return code;
    endfunction

endpackage : exc_ctrl_pkg
`default_nettype wire

// File: rtl/exc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : exc_ctrl
//  Brief   : MEM-stage exception/interrupt controller: CP0 write-back,
//            pipeline flush / PC redirect sequencing and stall vector
//  Rev     : 1.0  initial release
// ============================================================================
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    input  logic        inst_valid_i,
    input  logic        syscall_i,
    input  logic        invalid_i,
    input  logic        trap_i,
    input  logic        ovf_i,
    input  logic        eret_i,
    input  logic [31:0] inst_addr_i,
    input  logic        in_delayslot_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] cp0_inst_addr_o,
    output logic        cp0_in_delayslot_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic [5:0]  stall_o
);

    localparam logic [2:0] c_CNT_INIT = 3'(FLUSH_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nxt;
    logic [31:0] r_excepttype;
    logic [31:0] w_excepttype_nxt;
    logic [31:0] r_inst_addr;
    logic [31:0] w_inst_addr_nxt;
    logic        r_in_delayslot;
    logic        w_in_delayslot_nxt;
    logic        r_flush;
    logic        w_flush_nxt;
    logic [31:0] r_new_pc;
    logic [31:0] w_new_pc_nxt;
    logic [5:0]  r_stall;
    logic [5:0]  w_stall_nxt;

    logic        w_int_pending;
    logic [31:0] w_code;
    logic        w_event;
    logic        w_unused;

    // Interrupt needs IE=1, EXL=0 and a real instruction to attach the EPC to.
    assign w_int_pending = ((cp0_status_i[15:8] & cp0_cause_i[15:8]) != 8'h00)
                           && cp0_status_i[0] && !cp0_status_i[1] && inst_valid_i;

    assign w_code  = prio_enc(w_int_pending, inst_valid_i, syscall_i, invalid_i,
                              trap_i, ovf_i, eret_i);
    assign w_event = (w_code != c_ZERO_WORD);

    assign w_unused = ^{cp0_status_i[31:16], cp0_status_i[7:2],
                        cp0_cause_i[31:16], cp0_cause_i[7:0]};

    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_nxt          = r_cnt;
        w_excepttype_nxt   = c_ZERO_WORD;
        w_inst_addr_nxt    = c_ZERO_WORD;
        w_in_delayslot_nxt = 1'b0;
        w_flush_nxt        = 1'b0;
        w_new_pc_nxt       = c_ZERO_WORD;
        w_stall_nxt        = c_STALL_NONE;
        case (r_state)
            ST_IDLE: begin
                if (w_event) begin
                    w_state_nxt        = ST_FLUSH;
                    w_cnt_nxt          = c_CNT_INIT;
                    w_excepttype_nxt   = w_code;
                    w_inst_addr_nxt    = inst_addr_i;
                    w_in_delayslot_nxt = in_delayslot_i;
                    w_flush_nxt        = 1'b1;
                    w_new_pc_nxt       = (w_code == c_EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
                end else if (stallreq_ex_i) begin
                    w_stall_nxt = c_STALL_EX;
                end else if (stallreq_id_i) begin
                    w_stall_nxt = c_STALL_ID;
                end
            end
            ST_FLUSH: begin
                if (r_cnt == 3'd0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt    = r_cnt - 3'd1;
                    w_flush_nxt  = 1'b1;
                    w_new_pc_nxt = r_new_pc;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == c_RST_ACTIVE) begin
            r_state        <= ST_IDLE;
            r_cnt          <= 3'd0;
            r_excepttype   <= c_ZERO_WORD;
            r_inst_addr    <= c_ZERO_WORD;
            r_in_delayslot <= 1'b0;
            r_flush        <= 1'b0;
            r_new_pc       <= c_ZERO_WORD;
            r_stall        <= c_STALL_NONE;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_excepttype   <= w_excepttype_nxt;
            r_inst_addr    <= w_inst_addr_nxt;
            r_in_delayslot <= w_in_delayslot_nxt;
            r_flush        <= w_flush_nxt;
            r_new_pc       <= w_new_pc_nxt;
            r_stall        <= w_stall_nxt;
        end
    end

    assign excepttype_o       = r_excepttype;
    assign cp0_inst_addr_o    = r_inst_addr;
    assign cp0_in_delayslot_o = r_in_delayslot;
    assign flush_o            = r_flush;
    assign new_pc_o           = r_new_pc;
    assign stall_o            = r_stall;

endmodule : exc_ctrl
`default_nettype wire
